// File: rtl/vec_alu_pkg.sv
// Shared types and constants for the multi-lane sequential vector ALU.
//   alu_op_e        : 4-bit opcode encoding (11..15 are illegal)
//   vec_alu_state_e : control FSM states
//   FLAG_Z/FLAG_N   : bit positions inside each lane's 2-bit flag field
package vec_alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 2;
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;

    typedef enum logic [OP_W-1:0] {
        OP_SUB = 4'd0,
        OP_ADD = 4'd1,
        OP_MUL = 4'd2,
        OP_MOV = 4'd3,
        OP_CMP = 4'd4,
        OP_DIV = 4'd5,
        OP_XOR = 4'd6,
        OP_AND = 4'd7,
        OP_NOT = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } vec_alu_state_e;

endpackage

// File: rtl/alu_div_lane.sv
// Iterative signed divider for one lane: restoring division on operand
// magnitudes, one quotient bit per cycle, sign applied on the final cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : latch a/b and begin a WIDTH-cycle division
//   a, b     : signed dividend / divisor
//   done_c   : high during the last iteration cycle (combinational)
//   quot_c   : signed quotient, valid while done_c is high (combinational)
//   divz     : divisor of the current/last division was zero
module alu_div_lane #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] quot_c,
    output logic             divz
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, dvs_q, rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, zero_q, run_q;

    logic [WIDTH:0]   rem_sh, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d, quo_d;

    // One restoring step: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[WIDTH];
        rem_d  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], q_bit};
        done_c = run_q && (cnt_q == CNT_W'(WIDTH - 1));
        // Most-negative / -1 wraps back to most-negative naturally here.
        if (zero_q) begin
            quot_c = '0;
        end else if (neg_q) begin
            quot_c = WIDTH'(-quo_d);
        end else begin
            quot_c = quo_d;
        end
    end

    // Iteration state; the dividend register doubles as the quotient shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            run_q  <= 1'b0;
        end else if (start) begin
            quo_q  <= a[WIDTH-1] ? WIDTH'(-a) : a;
            dvs_q  <= b[WIDTH-1] ? WIDTH'(-b) : b;
            rem_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            zero_q <= (b == '0);
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

    assign divz = zero_q;

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-lane sequential vector ALU with valid/ready in and out.
// Single-cycle ops complete one cycle after acceptance; DIV runs WIDTH
// cycles across all lanes in parallel.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid/in_ready, in_op, in_a, in_b : request channel (lane i at [i*WIDTH +: WIDTH])
//   out_valid/out_ready, out_result, out_flags, out_divz, out_illegal : result channel
//   busy        : division in progress
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [2*LANES-1:0]     out_flags,
    output logic [LANES-1:0]       out_divz,
    output logic                   out_illegal,
    output logic                   busy
);

    vec_alu_state_e state_q, state_d;
    logic load_single, load_div, div_start;

    logic [WIDTH-1:0]  sc_res [LANES];
    logic [FLAG_W-1:0] sc_flg [LANES];
    logic [WIDTH-1:0]  dv_res [LANES];
    logic [FLAG_W-1:0] dv_flg [LANES];
    logic [LANES-1:0]  dv_dz, dv_done;
    logic              is_div, illegal_c, div_done;

    logic [LANES*WIDTH-1:0] result_q;
    logic [2*LANES-1:0]     flags_q;
    logic [LANES-1:0]       divz_q;
    logic                   illegal_q;

    assign is_div    = (in_op == OP_DIV);
    assign illegal_c = (in_op > OP_SHR);
    assign div_done  = &dv_done;

    // Per-lane single-cycle datapath and divider.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0]        a_l, b_l, res_c, q_c;
        logic signed [WIDTH-1:0] sra_c;
        logic [FLAG_W-1:0]       flg_c, dflg_c;
        logic                    upd_c, big_sh, dz, done_c;

        assign a_l    = in_a[i*WIDTH +: WIDTH];
        assign b_l    = in_b[i*WIDTH +: WIDTH];
        assign big_sh = (b_l >= WIDTH'(WIDTH));
        // Kept separate so the arithmetic shift stays in a signed context.
        assign sra_c  = $signed(a_l) >>> b_l;

        always_comb begin
            res_c = '0;
            upd_c = 1'b0;
            case (in_op)
                OP_SUB: begin res_c = a_l - b_l; upd_c = 1'b1; end
                OP_ADD: begin res_c = a_l + b_l; upd_c = 1'b1; end
                OP_MUL: begin res_c = a_l * b_l; upd_c = 1'b1; end
                OP_MOV: res_c = b_l;
                OP_CMP: begin res_c = a_l - b_l; upd_c = 1'b1; end
                OP_XOR: res_c = a_l ^ b_l;
                OP_AND: res_c = a_l & b_l;
                OP_NOT: res_c = ~b_l;
                OP_SHL: res_c = big_sh ? '0 : (a_l << b_l);
                OP_SHR: res_c = big_sh ? {WIDTH{a_l[WIDTH-1]}} : sra_c;
                default: res_c = '0;
            endcase
            flg_c = '0;
            if (upd_c) begin
                flg_c[FLAG_Z] = (res_c == '0);
                flg_c[FLAG_N] = res_c[WIDTH-1];
            end
        end

        alu_div_lane #(.WIDTH(WIDTH)) u_div (
            .clk    (clk),
            .rst    (rst),
            .start  (div_start),
            .a      (a_l),
            .b      (b_l),
            .done_c (done_c),
            .quot_c (q_c),
            .divz   (dz)
        );

        // Divide-by-zero lanes report no flags.
        always_comb begin
            dflg_c = '0;
            if (!dz) begin
                dflg_c[FLAG_Z] = (q_c == '0);
                dflg_c[FLAG_N] = q_c[WIDTH-1];
            end
        end

        assign sc_res[i]  = res_c;
        assign sc_flg[i]  = flg_c;
        assign dv_res[i]  = q_c;
        assign dv_flg[i]  = dflg_c;
        assign dv_dz[i]   = dz;
        assign dv_done[i] = done_c;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; DONE+out_ready accepts back-to-back.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        load_single = 1'b0;
        load_div    = 1'b0;
        div_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_DIV: begin
                busy = 1'b1;
                if (div_done) begin
                    load_div = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_ready && in_valid) begin
            if (is_div) begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end else begin
                load_single = 1'b1;
                state_d     = ST_DONE;
            end
        end
    end

    // Result registers: change only on load, so they hold through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            flags_q   <= '0;
            divz_q    <= '0;
            illegal_q <= 1'b0;
        end else if (load_single) begin
            for (int i = 0; i < LANES; i++) begin
                result_q[i*WIDTH +: WIDTH] <= sc_res[i];
                flags_q[2*i +: 2]          <= sc_flg[i];
            end
            divz_q    <= '0;
            illegal_q <= illegal_c;
        end else if (load_div) begin
            for (int i = 0; i < LANES; i++) begin
                result_q[i*WIDTH +: WIDTH] <= dv_res[i];
                flags_q[2*i +: 2]          <= dv_flg[i];
            end
            divz_q    <= dv_dz;
            illegal_q <= 1'b0;
        end
    end

    assign out_result  = result_q;
    assign out_flags   = flags_q;
    assign out_divz    = divz_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq at WIDTH=4, LANES=2 with directed vectors.
module tb_vec_alu_seq;
    import vec_alu_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned L = 2;

    typedef struct packed {
        logic [L*W-1:0] res;
        logic [2*L-1:0] flg;
        logic [L-1:0]   dz;
        logic           ill;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [3:0]     in_op;
    logic [L*W-1:0] in_a, in_b, out_result;
    logic [2*L-1:0] out_flags;
    logic [L-1:0]   out_divz;
    logic           out_illegal, busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_alu_seq #(.WIDTH(W), .LANES(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_divz    (out_divz),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [3:0] f,
                                input logic [1:0] d, input logic i);
        exp_t e;
        e.res = r; e.flg = f; e.dz = d; e.ill = i;
        return e;
    endfunction

    // Monitor: every handshaken result is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_result), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",  32'(out_result),  32'(e.res));
                check("flags",   32'(out_flags),   32'(e.flg));
                check("divz",    32'(out_divz),    32'(e.dz));
                check("illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else waits++;
        end
        check("accepted", 32'(acc), 32'd1);
        if (acc) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int bsy);
        cyc = 0;
        bsy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cyc++;
            if (busy && !in_ready) bsy++;
            if (out_valid) break;
        end
        check("valid_seen", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int w, c, bc;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_result",    32'(out_result), 32'd0);
        check("rst_flags",     32'(out_flags),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // SUB: one-cycle latency, lane0 -1 (N), lane1 0 (Z)
        @(posedge clk); #1;
        issue(4'(OP_SUB), 8'h22, 8'h23, mk(8'h0F, 4'b0110, 2'b00, 1'b0), w);
        wait_valid(c, bc);
        check("sub_latency", 32'(c), 32'd1);

        // Back-to-back single-cycle ops with in_valid held
        @(posedge clk); #1;
        issue(4'(OP_ADD), 8'h22, 8'h23, mk(8'h45, 4'b0000, 2'b00, 1'b0), w);
        issue(4'(OP_MUL), 8'h22, 8'h23, mk(8'h46, 4'b0000, 2'b00, 1'b0), w);
        check("b2b_mul_wait", 32'(w), 32'd0);
        issue(4'(OP_NOT), 8'h22, 8'h23, mk(8'hDC, 4'b0000, 2'b00, 1'b0), w);
        check("b2b_not_wait", 32'(w), 32'd0);
        issue(4'(OP_SHL), 8'h22, 8'h23, mk(8'h80, 4'b0000, 2'b00, 1'b0), w);
        check("b2b_shl_wait", 32'(w), 32'd0);
        issue(4'(OP_SHR), 8'h22, 8'h23, mk(8'h00, 4'b0000, 2'b00, 1'b0), w);
        check("b2b_shr_wait", 32'(w), 32'd0);
        // SHR with shift >= WIDTH sign-fills; CMP and MOV
        issue(4'(OP_SHR), 8'h7A, 8'h15, mk(8'h3F, 4'b0000, 2'b00, 1'b0), w);
        issue(4'(OP_CMP), 8'h22, 8'h23, mk(8'h0F, 4'b0110, 2'b00, 1'b0), w);
        issue(4'(OP_MOV), 8'h22, 8'h23, mk(8'h23, 4'b0000, 2'b00, 1'b0), w);
        repeat (3) @(posedge clk);
        #1;

        // DIV 7/-2 and -8/-1
        issue(4'(OP_DIV), 8'h87, 8'hFE, mk(8'h8D, 4'b1010, 2'b00, 1'b0), w);
        wait_valid(c, bc);
        check("div_latency", 32'(c), 32'd5);
        check("div_busy_cycles", 32'(bc), 32'd4);

        // DIV with lane0 divisor zero, lane1 6/3
        @(posedge clk); #1;
        issue(4'(OP_DIV), 8'h65, 8'h30, mk(8'h20, 4'b0000, 2'b01, 1'b0), w);
        wait_valid(c, bc);
        check("divz_latency", 32'(c), 32'd5);

        // Stall: output held while out_ready=0, then back-to-back accept
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'(OP_XOR), 8'h22, 8'h23, mk(8'h01, 4'b0000, 2'b00, 1'b0), w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid",    32'(out_valid),  32'd1);
            check("stall_result",   32'(out_result), 32'h01);
            check("stall_in_ready", 32'(in_ready),   32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'(OP_AND), 8'h22, 8'h23, mk(8'h22, 4'b0000, 2'b00, 1'b0), w);
        check("stall_release_wait", 32'(w), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset during DIV cycle 2 discards the operation
        issue(4'(OP_DIV), 8'h87, 8'hFE, mk(8'h8D, 4'b1010, 2'b00, 1'b0), w);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid),  32'd0);
        check("mid_rst_busy",      32'(busy),       32'd0);
        check("mid_rst_in_ready",  32'(in_ready),   32'd1);
        check("mid_rst_result",    32'(out_result), 32'd0);
        check("mid_rst_flags",     32'(out_flags),  32'd0);
        bc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) bc++;
        end
        check("no_partial_result", 32'(bc), 32'd0);

        @(posedge clk); #1;
        issue(4'(OP_ADD), 8'h22, 8'h23, mk(8'h45, 4'b0000, 2'b00, 1'b0), w);
        wait_valid(c, bc);
        @(posedge clk); #1;
        issue(4'd12, 8'h22, 8'h23, mk(8'h00, 4'b0000, 2'b00, 1'b1), w);
        wait_valid(c, bc);
        check("illegal_latency", 32'(c), 32'd1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
